// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: op encodings and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shifter_pkg;

    localparam int          OP_W       = 2;
    localparam logic [1:0]  OP_SLL_ENC = 2'b00;
    localparam logic [1:0]  OP_SRL_ENC = 2'b01;
    localparam logic [1:0]  OP_SRA_ENC = 2'b10;
    localparam logic [1:0]  OP_ROL_ENC = 2'b11;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = OP_SLL_ENC,
        OP_SRL = OP_SRL_ENC,
        OP_SRA = OP_SRA_ENC,
        OP_ROL = OP_ROL_ENC
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shifter_state_t;

endpackage

// File: rtl/shift_step.sv
// One partial shift/rotate of a WIDTH-wide word by 0..STEP positions.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: i_dat word in, i_amt amount, i_op mode, i_fill SRA fill bit, o_dat word out,
//        o_carry (ITER_SHIFTER_FLAGS_EN only) last bit shifted out, or result LSB for ROL.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic [WIDTH-1:0] i_dat,
    input  logic [AMT_W-1:0] i_amt,
    input  shift_op_t        i_op,
    input  logic             i_fill,
`ifdef ITER_SHIFTER_FLAGS_EN
    output logic             o_carry,
`endif
    output logic [WIDTH-1:0] o_dat
);

    always_comb begin
        o_dat = i_dat;
        case (i_op)
            OP_SLL: o_dat = i_dat << i_amt;
            OP_SRL: o_dat = i_dat >> i_amt;
            // Top i_amt bits come from the fill bit captured at accept.
            OP_SRA: o_dat = (i_dat >> i_amt) | (~({WIDTH{1'b1}} >> i_amt) & {WIDTH{i_fill}});
            // Amount 0 shifts right by WIDTH, which yields zero: no special case needed.
            OP_ROL: o_dat = (i_dat << i_amt) | (i_dat >> (WIDTH - int'(i_amt)));
            default: o_dat = i_dat;
        endcase
    end

`ifdef ITER_SHIFTER_FLAGS_EN
    logic [AMT_W-1:0] w_idx_l;
    logic [AMT_W-1:0] w_idx_r;

    // Only meaningful for i_amt > 0, which is the only case selected below.
    assign w_idx_l = AMT_W'(WIDTH - int'(i_amt));
    assign w_idx_r = i_amt - 1'b1;

    always_comb begin
        o_carry = 1'b0;
        if (i_amt != '0) begin
            case (i_op)
                OP_SLL:          o_carry = i_dat[w_idx_l];
                OP_SRL, OP_SRA:  o_carry = i_dat[w_idx_r];
                OP_ROL:          o_carry = o_dat[0];
                default:         o_carry = 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL unit shifting at most STEP positions per clock.
// Latency: out_valid rises 1+ceil(shamt/STEP) edges after the accept edge.
// Backpressure: holds result while out_ready=0; in_ready low from accept until the edge after the result is taken.
// Ports: clock/reset (async active-low), in_valid/in_ready + data_operandA/shamt/op request,
//        out_valid/out_ready + out result, busy (not idle).
// Optional macro ITER_SHIFTER_FLAGS_EN adds out_zero and out_carry, held alongside out.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
`ifdef ITER_SHIFTER_FLAGS_EN
    output logic               out_zero,
    output logic               out_carry,
`endif
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] STEP_S = SHAMT_W'(STEP);

    shifter_state_t     r_state;
    shift_op_t          r_op;
    logic               r_fill;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_rem;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out;
    logic               r_busy;

    logic [SHAMT_W-1:0] w_k;
    logic [WIDTH-1:0]   w_step_dat;

    assign w_k = (r_rem < STEP_S) ? r_rem : STEP_S;

`ifdef ITER_SHIFTER_FLAGS_EN
    logic w_step_carry;
    logic r_carry;
    logic r_out_zero;
    logic r_out_carry;
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (SHAMT_W)
    ) u_step (
        .i_dat   (r_work),
        .i_amt   (w_k),
        .i_op    (r_op),
        .i_fill  (r_fill),
`ifdef ITER_SHIFTER_FLAGS_EN
        .o_carry (w_step_carry),
`endif
        .o_dat   (w_step_dat)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_SLL;
            r_fill      <= 1'b0;
            r_work      <= '0;
            r_rem       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_busy      <= 1'b0;
`ifdef ITER_SHIFTER_FLAGS_EN
            r_carry     <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_carry <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_work     <= data_operandA;
                        r_op       <= shift_op_t'(op);
                        r_fill     <= data_operandA[WIDTH-1];
                        r_rem      <= shamt;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef ITER_SHIFTER_FLAGS_EN
                        r_carry    <= 1'b0;
`endif
                        r_state    <= (shamt == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        // Covers the first edge after reset release.
                        r_in_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_step_dat;
                    r_rem  <= r_rem - w_k;
`ifdef ITER_SHIFTER_FLAGS_EN
                    r_carry <= w_step_carry;
`endif
                    if (r_rem == w_k) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE edge publishes the result; later edges wait for the consumer.
                    if (!r_out_valid) begin
                        r_out       <= r_work;
                        r_out_valid <= 1'b1;
`ifdef ITER_SHIFTER_FLAGS_EN
                        r_out_zero  <= (r_work == '0);
                        r_out_carry <= r_carry;
`endif
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign busy      = r_busy;
`ifdef ITER_SHIFTER_FLAGS_EN
    assign out_zero  = r_out_zero;
    assign out_carry = r_out_carry;
`endif

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

    localparam int W  = 32;
    localparam int ST = 4;
    localparam int SW = $clog2(W);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  data_operandA = '0;
    logic [SW-1:0] shamt = '0;
    logic [1:0]    op = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out;
    logic          busy;
`ifdef ITER_SHIFTER_FLAGS_EN
    logic          out_zero;
    logic          out_carry;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    iter_shifter #(.WIDTH(W), .STEP(ST)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .shamt         (shamt),
        .op            (op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out           (out),
`ifdef ITER_SHIFTER_FLAGS_EN
        .out_zero      (out_zero),
        .out_carry     (out_carry),
`endif
        .busy          (busy)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-cycle reference: the whole shift in one expression.
    function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input int sh);
        logic [W-1:0] r;
        case (o)
            2'b00:   r = a << sh;
            2'b01:   r = a >> sh;
            2'b10:   r = $signed(a) >>> sh;
            default: r = (sh == 0) ? a : ((a << sh) | (a >> (W - sh)));
        endcase
        return r;
    endfunction

    function automatic logic ref_carry(input logic [1:0] o, input logic [W-1:0] a, input int sh);
        logic [W-1:0] r;
        if (sh == 0) return 1'b0;
        r = ref_res(o, a, sh);
        case (o)
            2'b00:   return a[W-sh];
            2'b01:   return a[sh-1];
            2'b10:   return a[sh-1];
            default: return r[0];
        endcase
    endfunction

    function automatic int ref_lat(input int sh);
        return 1 + (sh + ST - 1) / ST;
    endfunction

    // Transaction-level model: one request in flight, result due a fixed number of edges after accept.
    int           cyc = 0;
    int           m_due = 0;
    int           n_acc = 0;
    logic         m_pend = 1'b0, m_ovld = 1'b0, m_inrdy = 1'b0;
    logic [W-1:0] m_res = '0, m_out = '0;
    logic         m_rz = 1'b0, m_rc = 1'b0, m_zero = 1'b0, m_carry = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pend  <= 1'b0;
            m_ovld  <= 1'b0;
            m_inrdy <= 1'b0;
            m_out   <= '0;
            m_zero  <= 1'b0;
            m_carry <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_ovld && out_ready) begin
                m_ovld  <= 1'b0;
                m_pend  <= 1'b0;
                m_inrdy <= 1'b1;
            end else if (m_pend && !m_ovld && cyc == m_due) begin
                m_ovld  <= 1'b1;
                m_out   <= m_res;
                m_zero  <= m_rz;
                m_carry <= m_rc;
            end else if (!m_pend && m_inrdy && in_valid) begin
                m_pend  <= 1'b1;
                m_inrdy <= 1'b0;
                m_res   <= ref_res(op, data_operandA, int'(shamt));
                m_rz    <= (ref_res(op, data_operandA, int'(shamt)) == '0);
                m_rc    <= ref_carry(op, data_operandA, int'(shamt));
                m_due   <= cyc + ref_lat(int'(shamt));
                n_acc   <= n_acc + 1;
            end else if (!m_pend) begin
                m_inrdy <= 1'b1;
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clock) begin
        if (chk_en && reset) begin
            chk("mon_in_ready", in_ready, m_inrdy);
            chk("mon_out_valid", out_valid, m_ovld);
            chk("mon_busy", busy, m_pend);
            chk("mon_out", out, m_out);
`ifdef ITER_SHIFTER_FLAGS_EN
            chk("mon_zero", out_zero, m_zero);
            chk("mon_carry", out_carry, m_carry);
`endif
        end
    end

    // Issue one request, measure latency in edges, optionally hold off the consumer.
    task automatic do_req(input logic [1:0] o, input logic [W-1:0] a, input int sh,
                          input logic [W-1:0] exp, input int explat, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_in_ready_wait", (n < 50), 1'b1);
        in_valid      = 1'b1;
        data_operandA = a;
        shamt         = SW'(sh);
        op            = o;
        out_ready     = (hold == 0);
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("req_latency", n, explat);
        chk("req_result", out, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("bp_out_stable", out, exp);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("req_in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        int n;
        int start;

        // Pin the reference model with hand-computed values.
        chk("model_sll4", ref_res(2'b00, 32'h0000_00FF, 4), 32'h0000_0FF0);
        chk("model_sll0", ref_res(2'b00, 32'h0000_00FF, 0), 32'h0000_00FF);
        chk("model_sra31", ref_res(2'b10, 32'h8000_0010, 31), 32'hFFFF_FFFF);
        chk("model_srl31", ref_res(2'b01, 32'h8000_0010, 31), 32'h0000_0001);
        chk("model_rol8", ref_res(2'b11, 32'h1234_5678, 8), 32'h3456_7812);
        chk("model_rol0", ref_res(2'b11, 32'h1234_5678, 0), 32'h1234_5678);
        chk("model_lat31", ref_lat(31), 9);
        chk("model_carry_sll", ref_carry(2'b00, 32'h8000_0001, 1), 1'b1);

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", out, '0);
        chk("rst_busy", busy, 1'b0);
        #2 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rel_in_ready", in_ready, 1'b1);

        // Directed cases.
        do_req(2'b00, 32'h0000_00FF, 4,  32'h0000_0FF0, 2, 0);
        do_req(2'b00, 32'h0000_00FF, 0,  32'h0000_00FF, 1, 0);
        do_req(2'b10, 32'h8000_0010, 31, 32'hFFFF_FFFF, 9, 0);
        do_req(2'b01, 32'h8000_0010, 31, 32'h0000_0001, 9, 0);
        do_req(2'b11, 32'h1234_5678, 8,  32'h3456_7812, 3, 5);
        do_req(2'b11, 32'hCAFE_0001, 0,  32'hCAFE_0001, 1, 0);
`ifdef ITER_SHIFTER_FLAGS_EN
        do_req(2'b00, 32'h8000_0001, 1, 32'h0000_0002, 2, 0);
        chk("flag_sll_zero", out_zero, 1'b0);
        chk("flag_sll_carry", out_carry, 1'b1);
        do_req(2'b01, 32'h0000_0001, 1, 32'h0000_0000, 2, 0);
        chk("flag_srl_zero", out_zero, 1'b1);
        chk("flag_srl_carry", out_carry, 1'b1);
`endif

        // Reset in the middle of a long SLL.
        in_valid      = 1'b1;
        data_operandA = 32'h0000_0003;
        shamt         = SW'(20);
        op            = 2'b00;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("mid_busy_before", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out", out, '0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("mid_rel_in_ready", in_ready, 1'b1);
        n = 0;
        repeat (12) begin
            @(negedge clock);
            if (out_valid) n++;
        end
        chk("mid_no_stale", n, 0);

        // Randomised traffic, inputs toggling every cycle including while busy.
        start = n_acc;
        n = 0;
        while ((n_acc - start) < 2500 && n < 60000) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            data_operandA = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 | $urandom_range(0, 255) : $urandom;
            shamt         = SW'($urandom_range(0, W - 1));
            op            = 2'($urandom_range(0, 3));
            out_ready     = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            n++;
        end
        chk("rand_budget", (n < 60000), 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(negedge clock);
        chk("drain_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
